// File: rtl/load_control_pkg.sv
// Shared definitions for the program loader / run controller: command bytes
// received over the UART and the controller state encoding.
package load_control_pkg;

  localparam logic [7:0] CMD_LOAD     = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_CONT     = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP     = 8'h53;  // 'S'
  localparam logic [7:0] CMD_NEXT     = 8'h4E;  // 'N'
  localparam logic [7:0] CMD_STEP_END = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_CMD,
    ST_RUN,
    ST_STEP,
    ST_STEP_EXEC,
    ST_DUMP
  } state_t;

endpackage

// File: rtl/load_control_byte_packer.sv
// Little-endian byte-to-word assembler: each accepted byte enters at the top
// and the word shifts down, so the first byte ends up in bits 7:0.
module byte_packer #(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [7:0]       byte_in,
  output logic [NBITS-1:0] word_next,
  output logic             word_done
);

  logic [NBITS-1:0] word_q;
  logic [1:0]       count_q;

  assign word_next = {byte_in, word_q[NBITS-1:8]};
  assign word_done = shift_en && (count_q == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q  <= '0;
      count_q <= 2'd0;
    end else if (clear) begin
      word_q  <= '0;
      count_q <= 2'd0;
    end else if (shift_en) begin
      word_q  <= word_next;
      count_q <= count_q + 2'd1;
    end
  end

endmodule

// File: rtl/load_control.sv
// Loads a program into instruction memory from UART bytes, then runs the CPU
// continuously or single-stepped, requesting a debug dump after each run/step.
//
// state     | meaning
// IDLE      | wait for 'L'
// LOAD      | collect the four bytes of a word
// WRITE     | one-cycle instruction-memory write
// CMD       | wait for 'C' (continuous) or 'S' (step)
// RUN       | CPU enabled until program_end
// STEP      | wait for 'N' (one step) or 'E' (leave)
// STEP_EXEC | CPU enabled for one cycle
// DUMP      | send_flag held until send_done
module load_control
  import load_control_pkg::*;
#(
  parameter int               NBITS          = 32,
  parameter int               IM_ADDR_LENGTH = 32,
  parameter int               IM_MEM_SIZE    = 64,
  parameter logic [NBITS-1:0] HALT_WORD      = 32'hFFFFFFFF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_done,
  input  logic [7:0]                rx_Data,
  input  logic                      program_end,
  input  logic                      send_done,
  output logic [IM_ADDR_LENGTH-1:0] IM_Addr,
  output logic [NBITS-1:0]          IM_Data,
  output logic                      IM_we,
  output logic                      cpu_enable,
  output logic                      send_flag,
  output logic                      step_mode
);

  localparam logic [IM_ADDR_LENGTH-1:0] LAST_ADDR = IM_ADDR_LENGTH'(4 * (IM_MEM_SIZE - 1));

  state_t                    state_q, state_d;
  logic [IM_ADDR_LENGTH-1:0] im_addr_q;
  logic [NBITS-1:0]          im_data_q;
  logic                      step_q;
  logic                      end_q;
  logic                      pack_clear;
  logic                      pack_shift;
  logic                      word_done;
  logic [NBITS-1:0]          word_next;

  // A byte arriving in WRITE belongs to the next word, so WRITE shifts too.
  assign pack_shift = rx_done && ((state_q == ST_LOAD) || (state_q == ST_WRITE));
  assign pack_clear = rx_done && (state_q == ST_IDLE) && (rx_Data == CMD_LOAD);

  byte_packer #(.NBITS(NBITS)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pack_clear),
    .shift_en  (pack_shift),
    .byte_in   (rx_Data),
    .word_next (word_next),
    .word_done (word_done)
  );

  always_comb begin
    state_d    = state_q;
    IM_we      = 1'b0;
    cpu_enable = 1'b0;
    send_flag  = 1'b0;
    case (state_q)
      ST_IDLE:
        if (pack_clear) state_d = ST_LOAD;
      ST_LOAD:
        if (word_done) state_d = ST_WRITE;
      ST_WRITE: begin
        IM_we = 1'b1;
        if ((im_data_q == HALT_WORD) || (im_addr_q == LAST_ADDR)) state_d = ST_CMD;
        else                                                       state_d = ST_LOAD;
      end
      ST_CMD:
        if (rx_done) begin
          if (rx_Data == CMD_CONT)      state_d = ST_RUN;
          else if (rx_Data == CMD_STEP) state_d = ST_STEP;
        end
      ST_RUN: begin
        cpu_enable = !program_end;
        if (program_end) state_d = ST_DUMP;
      end
      ST_STEP:
        if (rx_done) begin
          if (rx_Data == CMD_NEXT)          state_d = ST_STEP_EXEC;
          else if (rx_Data == CMD_STEP_END) state_d = ST_IDLE;
        end
      ST_STEP_EXEC: begin
        cpu_enable = 1'b1;
        state_d    = ST_DUMP;
      end
      ST_DUMP: begin
        send_flag = 1'b1;
        if (send_done) state_d = (step_q && !end_q) ? ST_STEP : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      im_addr_q <= '0;
      im_data_q <= '0;
      step_q    <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // The address only advances when another word will follow, so a full
      // memory leaves it parked on the last written slot.
      if (pack_clear)
        im_addr_q <= '0;
      else if ((state_q == ST_WRITE) && (state_d == ST_LOAD))
        im_addr_q <= im_addr_q + IM_ADDR_LENGTH'(4);
      if (word_done) im_data_q <= word_next;
      if ((state_q == ST_CMD) && rx_done) begin
        if (rx_Data == CMD_CONT)      step_q <= 1'b0;
        else if (rx_Data == CMD_STEP) step_q <= 1'b1;
      end
      if ((state_q == ST_STEP_EXEC) && program_end)   end_q <= 1'b1;
      else if ((state_q == ST_DUMP) && send_done)     end_q <= 1'b0;
    end
  end

  assign IM_Addr   = im_addr_q;
  assign IM_Data   = im_data_q;
  assign step_mode = step_q;

endmodule

// File: doc/load_control.md
LOAD_CONTROL -- requirements
Module: load_control

Interface
REQ-001 The block SHALL have parameter NBITS, default 32, meaning instruction word width.
REQ-002 The block SHALL have parameter IM_ADDR_LENGTH, default 32, meaning instruction-memory byte-address width.
REQ-003 The block SHALL have parameter IM_MEM_SIZE, default 64, meaning instruction-memory capacity in words.
REQ-004 The block SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, meaning the end-of-program instruction.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port rx_done, input, 1 bit: one-cycle pulse from the UART receiver, meaning a byte is valid.
REQ-008 The block SHALL have port rx_Data, input, 8 bits: the received byte, valid when rx_done=1.
REQ-009 The block SHALL have port program_end, input, 1 bit: the CPU has executed HALT_WORD.
REQ-010 The block SHALL have port send_done, input, 1 bit: one-cycle pulse from send_control, meaning the debug dump is complete.
REQ-011 The block SHALL have port IM_Addr, output, IM_ADDR_LENGTH bits: the instruction-memory write byte address.
REQ-012 The block SHALL have port IM_Data, output, NBITS bits: the instruction-memory write data.
REQ-013 The block SHALL have port IM_we, output, 1 bit: instruction-memory write strobe.
REQ-014 The block SHALL have port cpu_enable, output, 1 bit: the pipeline advances while this is 1.
REQ-015 The block SHALL have port send_flag, output, 1 bit: request to send_control to start a dump; held until send_done.
REQ-016 The block SHALL have port step_mode, output, 1 bit: 1 = step mode, 0 = continuous mode.

Function
REQ-017 The block SHALL implement states IDLE, LOAD, WRITE, CMD, RUN, STEP, STEP_EXEC and DUMP.
REQ-018 IDLE: rx_done with byte 8'h4C ('L') SHALL go to LOAD with IM_Addr=0 and the byte count cleared; all other bytes SHALL be ignored.
REQ-019 LOAD: each rx_done SHALL shift rx_Data into the word, first byte into bits 7:0 (little-endian).
REQ-020 LOAD: on the 4th byte the block SHALL go to WRITE.
REQ-021 WRITE SHALL last exactly one cycle with IM_we=1 and IM_Data equal to the assembled word.
REQ-022 Leaving WRITE, IM_Addr SHALL increment by 4 and the next state SHALL be LOAD.
REQ-023 Leaving WRITE, the next state SHALL instead be CMD if the word equals HALT_WORD or IM_Addr equals 4*(IM_MEM_SIZE-1) (memory full, no wrap).
REQ-024 An rx_done arriving during WRITE SHALL be accepted as byte 0 of the next word.
REQ-025 CMD: byte 'C' (8'h43) SHALL clear step_mode and go to RUN; byte 'S' (8'h53) SHALL set step_mode and go to STEP; other bytes SHALL be ignored.
REQ-026 RUN SHALL hold cpu_enable=1; on program_end=1 it SHALL drop cpu_enable the same cycle (combinational) and go to DUMP.
REQ-027 STEP: byte 'N' (8'h4E) SHALL go to STEP_EXEC; byte 'E' (8'h45) SHALL go to IDLE.
REQ-028 STEP_EXEC SHALL assert cpu_enable for exactly one cycle, then go to DUMP.
REQ-029 DUMP SHALL hold send_flag=1 until send_done.
REQ-030 On send_done, DUMP SHALL return to STEP if step_mode=1 and the last step did not raise program_end; otherwise it SHALL go to IDLE.
REQ-031 A program_end seen in STEP_EXEC SHALL be latched so that the dump after it returns to IDLE.
REQ-032 IM_we, cpu_enable and send_flag SHALL never be 1 in the same cycle.

Reset
REQ-033 Assertion of reset (low) SHALL immediately force IDLE.
REQ-034 Reset SHALL clear IM_Addr, IM_Data, the byte count, the assembled word, step_mode and the program_end latch to 0.
REQ-035 IM_we, cpu_enable and send_flag SHALL be 0 during reset and in the first cycle after deassertion.
REQ-036 Reset mid-LOAD SHALL discard the partial word without a write.

Structure
REQ-037 A shared package SHALL hold the command-byte constants ('L','C','S','N','E') and the state encoding.
REQ-038 Byte-to-word assembly (shift register plus 2-bit byte counter) SHALL be one sub-module, byte_packer.

Verification
REQ-039 Load: 'L', then bytes 13,00,00,00 and FF,FF,FF,FF -> IM_we at IM_Addr 0 with 32'h00000013, IM_we at 4 with 32'hFFFFFFFF, then state CMD.
REQ-040 Continuous: 'C', program_end pulse 30 cycles later -> cpu_enable high 30 cycles, send_flag high until send_done, then IDLE.
REQ-041 Step: 'S', then 'N' x2, then 'E' -> two single-cycle cpu_enable pulses, each followed by a send_flag/send_done handshake, then IDLE.
REQ-042 Full memory: IM_MEM_SIZE=4, load 4 non-halt words -> last write at IM_Addr 12, then CMD, no wrap to 0.
REQ-043 Reset after 2 bytes of a word -> IM_we never asserted, state IDLE, IM_Addr=0.
REQ-044 Garbage: bytes 8'h00 in IDLE and 'X' in CMD -> no state change, all outputs 0.
